// File: rtl/differential_toggle_checker_if.sv
// Differential blinker link, receive side bundle.
// Pair legs in, lock/count/LED status out.
interface differential_toggle_checker_if #(
  parameter int unsigned COUNT_WIDTH = 32
);
  logic                   data_signal_positive_read;
  logic                   data_signal_negative_read;
  logic                   locked;
  logic [15:0]            edge_count;
  logic [15:0]            error_count;
  logic [COUNT_WIDTH-1:0] last_period;
  logic [7:0]             led;

  modport master (
    output data_signal_positive_read,
    output data_signal_negative_read,
    input  locked,
    input  edge_count,
    input  error_count,
    input  last_period,
    input  led
  );

  modport slave (
    input  data_signal_positive_read,
    input  data_signal_negative_read,
    output locked,
    output edge_count,
    output error_count,
    output last_period,
    output led
  );
endinterface

// File: rtl/differential_toggle_checker.sv
// Differential toggle checker: sync, edge detect,
// half-period measurement, lock FSM, error counting.
module differential_toggle_checker #(
  parameter int unsigned EXPECTED_HALF_PERIOD = 25116769,
  parameter int unsigned TOLERANCE            = 64,
  parameter int unsigned LOCK_COUNT           = 4,
  parameter int unsigned COUNT_WIDTH          = 32
) (
  input logic                     clock,
  input logic                     reset_n,
  differential_toggle_checker_if.slave link
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned CW = COUNT_WIDTH;

  localparam longint unsigned HI_L =
    64'(EXPECTED_HALF_PERIOD) + 64'(TOLERANCE);
  localparam longint unsigned LO_L =
    (EXPECTED_HALF_PERIOD > TOLERANCE) ?
    64'(EXPECTED_HALF_PERIOD) - 64'(TOLERANCE) : 64'd0;

  localparam logic [CW:0] HI = HI_L[CW:0];
  localparam logic [CW:0] LO = LO_L[CW:0];

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync2_q, prev_q;
  logic [CW-1:0]  counter_q, counter_d;
  logic [CW-1:0]  last_period_q, last_period_d;
  logic [15:0]    edge_cnt_q, edge_cnt_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [GW-1:0]  good_q, good_d;
  logic           err_seen_q, err_seen_d;

  logic           pair_s;
  logic           edge_s, good_s, bad_s, tmo_s;
  logic           err_ev;
  logic [CW:0]    cnt_inc;

  // Behavioural IBUFDS: the pair reads as P when the legs differ.
  assign pair_s = link.data_signal_positive_read &
                  ~link.data_signal_negative_read;

  // Two-flop synchroniser plus previous-value register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pair_s;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Edge qualification against the nominal half-period window.
  always_comb begin
    cnt_inc = {1'b0, counter_q} + (CW + 1)'(1);
    edge_s  = sync2_q ^ prev_q;
    good_s  = edge_s && (cnt_inc >= LO) && (cnt_inc <= HI);
    bad_s   = edge_s && !good_s;
    tmo_s   = !edge_s && ({1'b0, counter_q} == HI);
  end

  // Period counter, measurement and edge tally next-state.
  always_comb begin
    counter_d     = cnt_inc[CW] ? counter_q : cnt_inc[CW-1:0];
    last_period_d = last_period_q;
    edge_cnt_d    = edge_cnt_q;
    if (edge_s) begin
      counter_d     = '0;
      last_period_d = cnt_inc[CW] ? '1 : cnt_inc[CW-1:0];
      edge_cnt_d    = edge_cnt_q + 16'd1;
    end
  end

  // Lock FSM next-state and error bookkeeping.
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    err_ev     = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (edge_s) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (good_s) begin
          good_d = good_q + GW'(1);
          if (good_d == GW'(LOCK_COUNT)) begin
            state_d = LOCKED;
          end
        end else if (bad_s || tmo_s) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (bad_s || tmo_s) begin
          state_d = SEARCH;
          err_ev  = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
    err_cnt_d  = err_cnt_q;
    if (err_ev && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
    err_seen_d = err_seen_q | err_ev;
  end

  // State, counters and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      counter_q     <= '0;
      last_period_q <= '0;
      edge_cnt_q    <= '0;
      err_cnt_q     <= '0;
      good_q        <= '0;
      err_seen_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      last_period_q <= last_period_d;
      edge_cnt_q    <= edge_cnt_d;
      err_cnt_q     <= err_cnt_d;
      good_q        <= good_d;
      err_seen_q    <= err_seen_d;
    end
  end

  logic locked_s;
  assign locked_s         = (state_q == LOCKED);
  assign link.locked      = locked_s;
  assign link.edge_count  = edge_cnt_q;
  assign link.error_count = err_cnt_q;
  assign link.last_period = last_period_q;
  assign link.led         = {locked_s, locked_s & sync2_q,
                             err_seen_q, err_cnt_q[4:0]};

endmodule

// File: tb/tb_differential_toggle_checker.sv
// Bench for the differential toggle checker:
// vector table, corner sequences, random gaps.
module tb_differential_toggle_checker;

  localparam int EHP = 100;
  localparam int TOL = 4;
  localparam int LCK = 4;
  localparam int CW  = 16;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;
  bit   chk_on;

  differential_toggle_checker_if #(.COUNT_WIDTH(CW)) link();

  differential_toggle_checker #(
    .EXPECTED_HALF_PERIOD(EHP),
    .TOLERANCE(TOL),
    .LOCK_COUNT(LCK),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .link(link)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares < 30)
        $display("FAIL %s: got %0h expected %0h t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  // Reference model: a sample delay line and edge timestamps.
  bit hq[$];
  int cyc, lastc;
  bit m_ref, m_lock, m_seen;
  int m_streak, m_edges, m_err, m_last;

  function automatic void m_clear();
    hq = '{1'b0, 1'b0, 1'b0};
    cyc = 0; lastc = 0;
    m_ref = 0; m_lock = 0; m_seen = 0;
    m_streak = 0; m_edges = 0; m_err = 0; m_last = 0;
  endfunction

  function automatic void m_lose();
    m_lock = 0;
    m_ref  = 0;
    if (m_err < 65535) m_err++;
    m_seen = 1;
  endfunction

  function automatic void m_step(input bit dv);
    bit e, good;
    int since, p;
    cyc++;
    e = hq[1] != hq[2];
    hq.push_front(dv);
    void'(hq.pop_back());
    since = cyc - lastc;
    if (e) begin
      p = (since > 65535) ? 65535 : since;
      m_last  = p;
      m_edges = (m_edges + 1) % 65536;
      lastc   = cyc;
      good = (p >= EHP - TOL) && (p <= EHP + TOL);
      if (m_lock) begin
        if (!good) m_lose();
      end else if (m_ref) begin
        if (good) begin
          m_streak++;
          if (m_streak == LCK) m_lock = 1;
        end else begin
          m_ref = 0;
        end
      end else begin
        m_ref = 1;
        m_streak = 0;
      end
    end else if (since - 1 == EHP + TOL) begin
      if (m_lock) m_lose();
      else m_ref = 0;
    end
  endfunction

  initial m_clear();

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_clear();
    else m_step(link.data_signal_positive_read &&
                !link.data_signal_negative_read);
  end

  logic [56:0] dut_v, mod_v;
  logic [7:0]  m_led;

  // Every cycle, whole output bundle against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      m_led = {m_lock, m_lock & hq[1], m_seen, 5'(m_err)};
      dut_v = {link.locked, link.edge_count, link.error_count,
               link.last_period, link.led};
      mod_v = {m_lock, 16'(m_edges), 16'(m_err),
               16'(m_last), m_led};
      chk("cycle", 64'(dut_v), 64'(mod_v));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_pair(input bit v);
    link.data_signal_positive_read = v;
    link.data_signal_negative_read = ~v;
  endtask

  task automatic toggle();
    set_pair(~link.data_signal_positive_read);
  endtask

  // Toggle gap clocks after the previous one; return once
  // the resulting edge has been registered.
  task automatic pulse(input int gap);
    tick(gap - 3);
    toggle();
    tick(3);
  endtask

  task automatic relock();
    for (int i = 0; i < 5; i++) pulse(EHP);
  endtask

  typedef struct {
    int gap;
    bit locked;
    int err;
    int last;
    int edges;
    bit seen;
  } vec_t;

  vec_t tbl[21];
  int   r, g;

  initial begin
    vectors = 0;
    miscompares = 0;
    chk_on = 1;
    reset_n = 1'b0;
    set_pair(1'b0);

    tbl[0]  = '{50,  0, 0, -1,  1, 0};
    tbl[1]  = '{100, 0, 0, 100, 2, 0};
    tbl[2]  = '{100, 0, 0, 100, 3, 0};
    tbl[3]  = '{100, 0, 0, 100, 4, 0};
    tbl[4]  = '{100, 1, 0, 100, 5, 0};
    tbl[5]  = '{104, 1, 0, 104, 6, 0};
    tbl[6]  = '{105, 0, 1, 105, 7, 1};
    tbl[7]  = '{100, 0, 1, 100, 8, 1};
    tbl[8]  = '{100, 0, 1, 100, 9, 1};
    tbl[9]  = '{100, 0, 1, 100, 10, 1};
    tbl[10] = '{100, 0, 1, 100, 11, 1};
    tbl[11] = '{96,  1, 1, 96,  12, 1};
    tbl[12] = '{95,  0, 2, 95,  13, 1};
    tbl[13] = '{100, 0, 2, 100, 14, 1};
    tbl[14] = '{100, 0, 2, 100, 15, 1};
    tbl[15] = '{30,  0, 2, 30,  16, 1};
    tbl[16] = '{100, 0, 2, 100, 17, 1};
    tbl[17] = '{100, 0, 2, 100, 18, 1};
    tbl[18] = '{100, 0, 2, 100, 19, 1};
    tbl[19] = '{100, 0, 2, 100, 20, 1};
    tbl[20] = '{100, 1, 2, 100, 21, 1};

    // Reset held while the pair toggles.
    for (int i = 0; i < 6; i++) begin
      tick(7);
      toggle();
    end
    tick(1);
    chk("rst_hold_out",
        {link.locked, link.edge_count, link.error_count,
         link.last_period, link.led}, 57'd0);
    set_pair(1'b0);
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk("rst_rel_led", 64'(link.led), 64'h00);
    chk("rst_rel_lock", 64'(link.locked), 64'd0);

    // Lock, tolerance edges, relock, glitch in ACQUIRE.
    for (int i = 0; i < 21; i++) begin
      pulse(tbl[i].gap);
      chk($sformatf("tbl%0d_lock", i),
          64'(link.locked), 64'(tbl[i].locked));
      chk($sformatf("tbl%0d_err", i),
          64'(link.error_count), 64'(tbl[i].err));
      chk($sformatf("tbl%0d_edges", i),
          64'(link.edge_count), 64'(tbl[i].edges));
      chk($sformatf("tbl%0d_seen", i),
          64'(link.led[5]), 64'(tbl[i].seen));
      if (tbl[i].last >= 0)
        chk($sformatf("tbl%0d_last", i),
            64'(link.last_period), 64'(tbl[i].last));
    end
    chk("lock_led6", 64'(link.led[6]),
        64'(link.data_signal_positive_read));

    // Frozen input while locked: one timeout at counter 104.
    tick(104);
    chk("tmo_before", 64'(link.locked), 64'd1);
    tick(1);
    chk("tmo_lock", 64'(link.locked), 64'd0);
    chk("tmo_err", 64'(link.error_count), 64'd3);
    tick(200);
    chk("tmo_once", 64'(link.error_count), 64'd3);
    chk("tmo_edges", 64'(link.edge_count), 64'd21);

    // Error counter saturation.
    @(negedge clock);
    #2;
    force dut.err_cnt_q = 16'hFFFE;
    m_err = 16'hFFFE;
    #1;
    release dut.err_cnt_q;
    relock();
    chk("sat_relock", 64'(link.locked), 64'd1);
    pulse(50);
    chk("sat_hit", 64'(link.error_count), 64'hFFFF);
    relock();
    pulse(50);
    chk("sat_hold", 64'(link.error_count), 64'hFFFF);
    chk("sat_led", 64'(link.led), 64'h3F);

    // Asynchronous reset mid-lock, then a clean relock.
    relock();
    chk("pre_rst_lock", 64'(link.locked), 64'd1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_clr",
        {link.locked, link.edge_count, link.error_count,
         link.last_period, link.led}, 57'd0);
    set_pair(1'b0);
    tick(3);
    reset_n = 1'b1;
    relock();
    chk("rl_lock", 64'(link.locked), 64'd1);
    chk("rl_edges", 64'(link.edge_count), 64'd5);
    chk("rl_err", 64'(link.error_count), 64'd0);
    chk("rl_last", 64'(link.last_period), 64'd100);
    chk("rl_led", 64'(link.led), 64'hC0);

    // Random gaps against the model.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) g = 95 + $urandom_range(0, 10);
      else if (r == 7) g = $urandom_range(20, 40);
      else if (r == 8) g = 150;
      else g = ($urandom_range(0, 1) == 1) ? 104 : 105;
      pulse(g);
    end
    tick(10);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
